// File: rtl/stack_pop_sequencer_if.sv
// -----------------------------------------------------------------------------
// stack_pop_sequencer_if
// Bundles the request, data-memory read port and result signals of the
// RET/RTI stack pop sequencer.
//
//   slave  modport : the sequencer itself
//                    in : start_ret, start_rti, sp_in, mem_rd_data
//                    out: mem_read, mem_addr, busy, done, pc_out, flags_out,
//                         flags_valid, sp_out
//   master modport : the surrounding pipeline / memory (mirror directions)
//
// Parameters: W  = data word / stack pointer width
//             AW = data memory address width
// -----------------------------------------------------------------------------
interface stack_pop_sequencer_if #(
    parameter int W  = 16,
    parameter int AW = 11
);
    logic             start_ret;
    logic             start_rti;
    logic [W-1:0]     sp_in;
    logic [W-1:0]     mem_rd_data;
    logic             mem_read;
    logic [AW-1:0]    mem_addr;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   pc_out;
    logic [2:0]       flags_out;
    logic             flags_valid;
    logic [W-1:0]     sp_out;

    modport slave (
        input  start_ret,
        input  start_rti,
        input  sp_in,
        input  mem_rd_data,
        output mem_read,
        output mem_addr,
        output busy,
        output done,
        output pc_out,
        output flags_out,
        output flags_valid,
        output sp_out
    );

    modport master (
        output start_ret,
        output start_rti,
        output sp_in,
        output mem_rd_data,
        input  mem_read,
        input  mem_addr,
        input  busy,
        input  done,
        input  pc_out,
        input  flags_out,
        input  flags_valid,
        input  sp_out
    );
endinterface

// File: rtl/stack_pop_sequencer.sv
// -----------------------------------------------------------------------------
// stack_pop_sequencer
// Memory-stage read-side sequencer for RET/RTI. Pops the return PC (two words,
// high half first) and, for RTI, a flags word from the data stack, then hands
// the PC, flags and updated stack pointer back to fetch / the flag register.
//
// Stack layout read: sp+1 = pc[31:16], sp+2 = pc[15:0], sp+3 = {13'b0, flags}.
//
// Ports
//   clk  : system clock, all state on the rising edge
//   rst  : asynchronous, active-high reset
//   bus  : stack_pop_sequencer_if.slave
//          start_ret / start_rti : pop requests, only honoured while idle
//                                  (RTI wins if both are high)
//          sp_in                 : stack pointer, latched on an accepted start
//          mem_rd_data           : read data, valid the cycle after mem_read
//          mem_read / mem_addr   : single-word read strobe and address
//          busy                  : pipeline stall, high in every non-idle state
//          done                  : one-cycle pulse, results valid
//          pc_out / sp_out / flags_out : registered results, held until the
//                                  next pop completes
//          flags_valid           : high with done for an RTI pop
//
// Timing (start accepted at edge 0): reads issued in cycles 1,2(,3), data
// returns one cycle later, done is high in cycle 4 (RET) or 5 (RTI).
// -----------------------------------------------------------------------------
module stack_pop_sequencer #(
    parameter int W  = 16,
    parameter int AW = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    stack_pop_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_POP_HI = 3'd1,
        S_POP_LO = 3'd2,
        S_POP_FL = 3'd3,
        S_WAIT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t          state_q;
    logic            kind_rti_q;     // 1: RTI pop (3 words), 0: RET pop (2 words)
    logic [W-1:0]    sp_q;           // stack pointer latched at start
    logic [W-1:0]    hi_q;           // captured pc[31:16]
    logic [W-1:0]    lo_q;           // captured pc[15:0]

    logic            mem_read_q;
    logic [AW-1:0]   mem_addr_q;
    logic            busy_q;
    logic            done_q;
    logic [2*W-1:0]  pc_q;
    logic [2:0]      flags_q;
    logic            flags_valid_q;
    logic [W-1:0]    sp_out_q;

    // Next read addresses and final stack pointer values.
    // Truncating the stack pointer to AW bits before adding gives the same
    // low AW bits as adding in W bits first, so the address adders stay
    // AW bits wide; wrap-around is silent in both cases.
    logic [AW-1:0]   addr_p1_d;
    logic [AW-1:0]   addr_p2_d;
    logic [AW-1:0]   addr_p3_d;
    logic [W-1:0]    sp_p2_d;
    logic [W-1:0]    sp_p3_d;

    // Address and stack pointer arithmetic for the pop sequence.
    always_comb begin
        addr_p1_d = bus.sp_in[AW-1:0] + AW'(2'd1);
        addr_p2_d = sp_q[AW-1:0]      + AW'(2'd2);
        addr_p3_d = sp_q[AW-1:0]      + AW'(2'd3);
        sp_p2_d   = sp_q + W'(2'd2);
        sp_p3_d   = sp_q + W'(2'd3);
    end

    // Pop sequencer FSM with registered memory strobes, status and results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            kind_rti_q    <= 1'b0;
            sp_q          <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            mem_read_q    <= 1'b0;
            mem_addr_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pc_q          <= '0;
            flags_q       <= 3'b000;
            flags_valid_q <= 1'b0;
            sp_out_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q        <= 1'b0;
                    flags_valid_q <= 1'b0;
                    if (bus.start_rti || bus.start_ret) begin
                        // RTI has priority when both requests arrive together.
                        kind_rti_q <= bus.start_rti;
                        sp_q       <= bus.sp_in;
                        mem_read_q <= 1'b1;
                        mem_addr_q <= addr_p1_d;
                        busy_q     <= 1'b1;
                        state_q    <= S_POP_HI;
                    end else begin
                        mem_read_q <= 1'b0;
                        mem_addr_q <= '0;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end

                S_POP_HI: begin
                    // Read of sp+1 is on the bus; issue sp+2 next.
                    mem_read_q <= 1'b1;
                    mem_addr_q <= addr_p2_d;
                    state_q    <= S_POP_LO;
                end

                S_POP_LO: begin
                    // Data for sp+1 (pc high half) is valid this cycle.
                    hi_q <= bus.mem_rd_data;
                    if (kind_rti_q) begin
                        mem_read_q <= 1'b1;
                        mem_addr_q <= addr_p3_d;
                        state_q    <= S_POP_FL;
                    end else begin
                        mem_read_q <= 1'b0;
                        mem_addr_q <= '0;
                        state_q    <= S_WAIT;
                    end
                end

                S_POP_FL: begin
                    // Data for sp+2 (pc low half) is valid this cycle.
                    lo_q       <= bus.mem_rd_data;
                    mem_read_q <= 1'b0;
                    mem_addr_q <= '0;
                    state_q    <= S_WAIT;
                end

                S_WAIT: begin
                    // Last outstanding word arrives; results are published
                    // on the same edge so they are valid together with done.
                    mem_read_q <= 1'b0;
                    mem_addr_q <= '0;
                    done_q     <= 1'b1;
                    if (kind_rti_q) begin
                        // Only the low three bits of the flags word are meaningful.
                        flags_q       <= bus.mem_rd_data[2:0];
                        pc_q          <= {hi_q, lo_q};
                        sp_out_q      <= sp_p3_d;
                        flags_valid_q <= 1'b1;
                    end else begin
                        lo_q          <= bus.mem_rd_data;
                        pc_q          <= {hi_q, bus.mem_rd_data};
                        sp_out_q      <= sp_p2_d;
                        flags_valid_q <= 1'b0;
                    end
                    state_q <= S_DONE;
                end

                S_DONE: begin
                    // Requests seen in this cycle are dropped; the next
                    // request must arrive while idle.
                    done_q        <= 1'b0;
                    flags_valid_q <= 1'b0;
                    busy_q        <= 1'b0;
                    mem_read_q    <= 1'b0;
                    mem_addr_q    <= '0;
                    state_q       <= S_IDLE;
                end

                default: begin
                    state_q       <= S_IDLE;
                    mem_read_q    <= 1'b0;
                    mem_addr_q    <= '0;
                    busy_q        <= 1'b0;
                    done_q        <= 1'b0;
                    flags_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_read    = mem_read_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pc_out      = pc_q;
    assign bus.flags_out   = flags_q;
    assign bus.flags_valid = flags_valid_q;
    assign bus.sp_out      = sp_out_q;

endmodule

// File: tb/tb_stack_pop_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stack_pop_sequencer
// Directed and randomized pops against a reference built from the stack
// layout rules: each pop reads sp+1, sp+2 (and sp+3 for RTI) modulo 2^16,
// truncated to an 11-bit address, and returns the assembled PC, flags and
// sp+2 / sp+3.
// -----------------------------------------------------------------------------
module tb_stack_pop_sequencer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    stack_pop_sequencer_if #(.W(16), .AW(11)) bus ();

    stack_pop_sequencer #(.W(16), .AW(11)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] mem [0:2047];

    int checks   = 0;
    int failures = 0;

    // Reference state: the values pc_out / sp_out / flags_out should hold.
    logic [31:0] model_pc;
    logic [15:0] model_sp;
    logic [2:0]  model_flags;

    // Data memory: read data appears the cycle after the strobe; garbage otherwise.
    always @(posedge clk or posedge rst) begin
        if (rst)
            bus.mem_rd_data <= 16'h0000;
        else if (bus.mem_read)
            bus.mem_rd_data <= mem[bus.mem_addr];
        else
            bus.mem_rd_data <= 16'($urandom);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Address of stack word sp+k: 16-bit modulo sum, then low 11 bits.
    function automatic logic [10:0] addr_of(input logic [15:0] sp, input int k);
        int s;
        s = (int'(sp) + k) % 65536;
        return 11'(s % 2048);
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, " mem_read"},    64'(bus.mem_read),    64'd0);
        check({tag, " mem_addr"},    64'(bus.mem_addr),    64'd0);
        check({tag, " busy"},        64'(bus.busy),        64'd0);
        check({tag, " done"},        64'(bus.done),        64'd0);
        check({tag, " pc_out"},      64'(bus.pc_out),      64'd0);
        check({tag, " flags_out"},   64'(bus.flags_out),   64'd0);
        check({tag, " flags_valid"}, 64'(bus.flags_valid), 64'd0);
        check({tag, " sp_out"},      64'(bus.sp_out),      64'd0);
    endtask

    // One complete pop observed over 10 cycles after the accepting edge.
    // inject: spurious starts during POP_LO (cycle 2) and DONE (last busy cycle).
    task automatic run_pop(input bit do_ret, input bit do_rti, input logic [15:0] sp,
                           input bit inject, input string name);
        int nreads;
        int lat;
        int dones;
        int busy_cnt;
        bit rti;
        rti    = do_rti;
        nreads = rti ? 3 : 2;
        lat    = rti ? 5 : 4;
        model_pc = {mem[addr_of(sp, 1)], mem[addr_of(sp, 2)]};
        model_sp = 16'((int'(sp) + nreads) % 65536);
        if (rti)
            model_flags = mem[addr_of(sp, 3)][2:0];
        dones    = 0;
        busy_cnt = 0;
        #2;
        bus.start_ret = do_ret;
        bus.start_rti = do_rti;
        bus.sp_in     = sp;
        @(posedge clk);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            #1;
            bus.start_rti = (inject && cyc == 2) ? 1'b1 : 1'b0;
            bus.start_ret = (inject && (cyc == 2 || cyc == lat)) ? 1'b1 : 1'b0;
            bus.sp_in     = 16'($urandom);
            if (bus.done === 1'b1) dones++;
            if (bus.busy === 1'b1) busy_cnt++;
            check({name, " busy"},        64'(bus.busy),        64'(cyc <= lat));
            check({name, " done"},        64'(bus.done),        64'(cyc == lat));
            check({name, " flags_valid"}, 64'(bus.flags_valid), 64'(cyc == lat && rti));
            check({name, " mem_read"},    64'(bus.mem_read),    64'(cyc <= nreads));
            if (cyc <= nreads)
                check({name, " mem_addr"}, 64'(bus.mem_addr), 64'(addr_of(sp, cyc)));
            else if (cyc > lat)
                check({name, " idle mem_addr"}, 64'(bus.mem_addr), 64'd0);
            if (cyc == lat || cyc == 10) begin
                check({name, " pc_out"},    64'(bus.pc_out),    64'(model_pc));
                check({name, " sp_out"},    64'(bus.sp_out),    64'(model_sp));
                check({name, " flags_out"}, 64'(bus.flags_out), 64'(model_flags));
            end
            @(posedge clk);
        end
        check({name, " done count"}, 64'(dones),    64'd1);
        check({name, " busy cycles"}, 64'(busy_cnt), 64'(lat));
    endtask

    initial begin
        bus.start_ret = 1'b0;
        bus.start_rti = 1'b0;
        bus.sp_in     = 16'h0000;
        model_pc      = 32'h0;
        model_sp      = 16'h0;
        model_flags   = 3'b000;
        for (int i = 0; i < 2048; i++)
            mem[i] = 16'($urandom);

        // Power-on reset
        rst = 1'b1;
        #1;
        check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // RET from 0x07F0
        mem[11'h7F1] = 16'h0012;
        mem[11'h7F2] = 16'h3456;
        run_pop(1'b1, 1'b0, 16'h07F0, 1'b0, "ret_dir");
        check("ret_dir pc const", 64'(bus.pc_out), 64'h0000_0000_0012_3456);
        check("ret_dir sp const", 64'(bus.sp_out), 64'h07F2);

        // RTI from 0x0100
        mem[11'h101] = 16'hABCD;
        mem[11'h102] = 16'h0042;
        mem[11'h103] = 16'hFFFD;
        run_pop(1'b0, 1'b1, 16'h0100, 1'b0, "rti_dir");
        check("rti_dir pc const",    64'(bus.pc_out),    64'h0000_0000_ABCD_0042);
        check("rti_dir flags const", 64'(bus.flags_out), 64'h5);
        check("rti_dir sp const",    64'(bus.sp_out),    64'h0103);

        // RTI with stack pointer wrap
        run_pop(1'b0, 1'b1, 16'hFFFE, 1'b0, "rti_wrap");
        check("rti_wrap sp const", 64'(bus.sp_out), 64'h0001);

        // Both requests together plus ignored starts in POP_LO and DONE
        run_pop(1'b1, 1'b1, 16'h0400, 1'b1, "both_inject");

        // RET after the RTI: flags must not change
        run_pop(1'b1, 1'b0, 16'h0222, 1'b1, "ret_keep_flags");

        // Reset in the middle of a pop
        #2;
        bus.start_ret = 1'b1;
        bus.sp_in     = 16'h0200;
        @(posedge clk);
        #1;
        bus.start_ret = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        model_pc    = 32'h0;
        model_sp    = 16'h0;
        model_flags = 3'b000;
        check_outputs_zero("mid_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("post_reset done", 64'(bus.done), 64'd0);
            check("post_reset busy", 64'(bus.busy), 64'd0);
        end
        run_pop(1'b1, 1'b0, 16'h0010, 1'b0, "ret_after_reset");

        // Randomized pops
        for (int n = 0; n < 12; n++) begin
            logic [15:0] sp;
            bit r_ret;
            bit r_rti;
            sp    = (n % 4 == 0) ? 16'(16'hFFFC + $urandom_range(0, 3)) : 16'($urandom);
            r_rti = 1'($urandom);
            r_ret = r_rti ? 1'($urandom) : 1'b1;
            for (int k = 1; k <= 3; k++)
                mem[addr_of(sp, k)] = 16'($urandom);
            run_pop(r_ret, r_rti, sp, 1'($urandom), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
